// File: rtl/xs_sdr_rom_arbiter_if.sv
// ---------------------------------------------------------------------------
// xs_sdr_rom_arbiter_if
// Bundles the three graphics ROM fetch ports (OBJ, BACK1, BACK2) and the
// SDRAM controller read port served by xs_sdr_rom_arbiter.
//   obj_/bg1_/bg2_ addr, req : client request (4-phase, addr stable while req)
//   obj_/bg1_/bg2_ rdy, dout : returned data, held until req drops
//   sdram_addr, sdram_rd     : single-word read issued to the controller
//   sdram_ack, sdram_dout    : read completion from the controller
// Modports:
//   master : the side that owns the clients and the SDRAM controller
//   slave  : the arbiter, which answers clients and drives the read port
// ---------------------------------------------------------------------------
interface xs_sdr_rom_arbiter_if #(
   parameter int unsigned AW = 25,
   parameter int unsigned DW = 16
) ();
   logic [AW-1:0] obj_addr;
   logic          obj_req;
   logic          obj_rdy;
   logic [DW-1:0] obj_dout;
   logic [AW-1:0] bg1_addr;
   logic          bg1_req;
   logic          bg1_rdy;
   logic [DW-1:0] bg1_dout;
   logic [AW-1:0] bg2_addr;
   logic          bg2_req;
   logic          bg2_rdy;
   logic [DW-1:0] bg2_dout;
   logic [AW-1:0] sdram_addr;
   logic          sdram_rd;
   logic          sdram_ack;
   logic [DW-1:0] sdram_dout;

   modport slave (
      input  obj_addr, obj_req, bg1_addr, bg1_req, bg2_addr, bg2_req,
      input  sdram_ack, sdram_dout,
      output obj_rdy, obj_dout, bg1_rdy, bg1_dout, bg2_rdy, bg2_dout,
      output sdram_addr, sdram_rd
   );

   modport master (
      output obj_addr, obj_req, bg1_addr, bg1_req, bg2_addr, bg2_req,
      output sdram_ack, sdram_dout,
      input  obj_rdy, obj_dout, bg1_rdy, bg1_dout, bg2_rdy, bg2_dout,
      input  sdram_addr, sdram_rd
   );
endinterface

// File: rtl/xs_sdr_rom_arbiter.sv
// ---------------------------------------------------------------------------
// xs_sdr_rom_arbiter
// SDRAM-side responder for the OBJ, BACK1 and BACK2 graphics ROM fetch ports.
// Pending client requests are arbitrated round-robin (OBJ->BG1->BG2->OBJ),
// each winner gets one 16-bit SDRAM read, and the data is returned on that
// client's rdy/dout, held until the client drops req.
// Ports:
//   CLK : system clock, rising edge
//   RST : asynchronous active-high reset
//   bus : xs_sdr_rom_arbiter_if.slave (client ports + SDRAM read port)
// Optional build macro XS_SDR_LASTWORD_CACHE_EN: each client remembers its
// last completed {addr, data}; a repeat request for that addr is answered
// one edge later without touching SDRAM.
// ---------------------------------------------------------------------------
module xs_sdr_rom_arbiter #(
   parameter int unsigned AW = 25,
   parameter int unsigned DW = 16
) (
   input logic                 CLK,
   input logic                 RST,
   xs_sdr_rom_arbiter_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StIssue, StWait} arb_st_e;
   // CliBusy = granted and still wanted; if req drops there, the read's data
   // is discarded even if the client re-requests before the ack returns.
   typedef enum logic [1:0] {CliFree, CliPend, CliBusy, CliDone} cli_st_e;

   arb_st_e       st_q;
   cli_st_e       cli_q [3];
   logic [1:0]    ptr_q;
   logic [1:0]    gnt_q;
   logic [AW-1:0] sdram_addr_q;
   logic          sdram_rd_q;
   logic [2:0]    rdy_q;
   logic [DW-1:0] dout_q [3];

   logic [2:0]    req;
   logic [AW-1:0] addr [3];
   logic [2:0]    pend;
   logic [2:0]    hit;
   logic          gnt_vld;
   logic [1:0]    gnt_idx;
   logic [1:0]    cand;
   logic          ack_ok;

   assign req     = {bus.bg2_req, bus.bg1_req, bus.obj_req};
   assign addr[0] = bus.obj_addr;
   assign addr[1] = bus.bg1_addr;
   assign addr[2] = bus.bg2_addr;

   assign bus.obj_rdy    = rdy_q[0];
   assign bus.bg1_rdy    = rdy_q[1];
   assign bus.bg2_rdy    = rdy_q[2];
   assign bus.obj_dout   = dout_q[0];
   assign bus.bg1_dout   = dout_q[1];
   assign bus.bg2_dout   = dout_q[2];
   assign bus.sdram_addr = sdram_addr_q;
   assign bus.sdram_rd   = sdram_rd_q;

   // Acks outside WAIT (after reset or a cancel) are simply ignored.
   assign ack_ok = (st_q == StWait) && bus.sdram_ack;

   function automatic logic [1:0] nxt(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

`ifdef XS_SDR_LASTWORD_CACHE_EN
   logic [2:0]    cv_q;
   logic [AW-1:0] ca_q [3];
   logic [DW-1:0] cd_q [3];

   always_comb begin
      hit = '0;
      for (int i = 0; i < 3; i++) begin
         hit[i] = cv_q[i] && (ca_q[i] == addr[i]);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cv_q <= '0;
         for (int i = 0; i < 3; i++) begin
            ca_q[i] <= '0;
            cd_q[i] <= '0;
         end
      end else if (ack_ok) begin
         // Refreshed on every completed read, including discarded ones.
         cv_q[gnt_q] <= 1'b1;
         ca_q[gnt_q] <= sdram_addr_q;
         cd_q[gnt_q] <= bus.sdram_dout;
      end
   end
`else
   assign hit = '0;
`endif

   // Only clients still holding req are eligible, so a cancel before grant
   // never reaches SDRAM.
   always_comb begin
      pend = '0;
      for (int i = 0; i < 3; i++) begin
         pend[i] = (cli_q[i] == CliPend) && req[i];
      end
   end

   // First pending client strictly after the pointer.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = ptr_q;
      cand    = ptr_q;
      for (int k = 0; k < 3; k++) begin
         cand = nxt(cand);
         if (!gnt_vld && pend[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         st_q         <= StIdle;
         ptr_q        <= 2'd2;
         gnt_q        <= 2'd0;
         sdram_addr_q <= '0;
         sdram_rd_q   <= 1'b0;
         rdy_q        <= '0;
         for (int i = 0; i < 3; i++) begin
            cli_q[i]  <= CliFree;
            dout_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            unique case (cli_q[i])
               CliFree: begin
                  if (req[i]) begin
                     if (hit[i]) begin
                        cli_q[i] <= CliDone;
                        rdy_q[i] <= 1'b1;
`ifdef XS_SDR_LASTWORD_CACHE_EN
                        dout_q[i] <= cd_q[i];
`endif
                     end else begin
                        cli_q[i] <= CliPend;
                     end
                  end
               end
               CliPend: begin
                  if (!req[i]) begin
                     cli_q[i] <= CliFree;
                  end else if (st_q == StIdle && gnt_vld && gnt_idx == 2'(i)) begin
                     cli_q[i] <= CliBusy;
                  end
               end
               CliBusy: begin
                  if (!req[i]) begin
                     cli_q[i] <= CliFree;
                  end else if (ack_ok && gnt_q == 2'(i)) begin
                     cli_q[i]  <= CliDone;
                     rdy_q[i]  <= 1'b1;
                     dout_q[i] <= bus.sdram_dout;
                  end
               end
               CliDone: begin
                  if (!req[i]) begin
                     cli_q[i] <= CliFree;
                     rdy_q[i] <= 1'b0;
                  end
               end
               default: cli_q[i] <= CliFree;
            endcase
         end

         unique case (st_q)
            StIdle: begin
               if (gnt_vld) begin
                  ptr_q        <= gnt_idx;
                  gnt_q        <= gnt_idx;
                  sdram_addr_q <= addr[gnt_idx];
                  sdram_rd_q   <= 1'b1;
                  st_q         <= StIssue;
               end
            end
            StIssue: begin
               sdram_rd_q <= 1'b0;
               st_q       <= StWait;
            end
            StWait: begin
               if (bus.sdram_ack) begin
                  st_q <= StIdle;
               end
            end
            default: st_q <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_xs_sdr_rom_arbiter.sv
module tb_xs_sdr_rom_arbiter;
   localparam int unsigned AW = 25;
   localparam int unsigned DW = 16;

   logic CLK;
   logic RST;

   xs_sdr_rom_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   xs_sdr_rom_arbiter #(.AW(AW), .DW(DW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   logic [AW-1:0] c_addr [3];
   logic [2:0]    c_req;
   logic [2:0]    rdy_w;
   logic [DW-1:0] dout_w [3];

   assign bus.obj_addr = c_addr[0];
   assign bus.bg1_addr = c_addr[1];
   assign bus.bg2_addr = c_addr[2];
   assign bus.obj_req  = c_req[0];
   assign bus.bg1_req  = c_req[1];
   assign bus.bg2_req  = c_req[2];
   assign rdy_w        = {bus.bg2_rdy, bus.bg1_rdy, bus.obj_rdy};
   assign dout_w[0]    = bus.obj_dout;
   assign dout_w[1]    = bus.bg1_dout;
   assign dout_w[2]    = bus.bg2_dout;

   // SDRAM responder controls and log
   logic [AW-1:0] rd_log [$];
   int rd_cnt     = 0;
   int resp_en    = 1;
   int rand_delay = 0;
   int ack_delay  = 5;
   int stray_cnt  = 0;

   // Reference model: round-robin pointer (index of last served client).
   int ptr_m = 2;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
      if (a == 25'h123) return 16'hBEEF;
      return a[15:0] ^ {a[24:16], 7'h2B} ^ 16'h3C5A;
   endfunction

   // Expected service order for clients that all raise req together.
   task automatic model_order(input logic [2:0] mask, output int ord [3], output int n);
      n = 0;
      for (int k = 1; k <= 3; k++) begin
         int idx;
         idx = (ptr_m + k) % 3;
         ord[k-1] = 0;
         if (mask[idx]) begin
            ord[n] = idx;
            n++;
         end
      end
      if (n > 0) ptr_m = ord[n-1];
   endtask

   initial begin
      int d;
      int served;
      logic [AW-1:0] a;
      served = 0;
      bus.sdram_ack  = 1'b0;
      bus.sdram_dout = '0;
      forever begin
         @(negedge CLK);
         if (stray_cnt != served) begin
            served++;
            bus.sdram_ack  = 1'b1;
            bus.sdram_dout = 16'hDEAD;
            @(negedge CLK);
            bus.sdram_ack = 1'b0;
         end else if (bus.sdram_rd === 1'b1 && !RST) begin
            a = bus.sdram_addr;
            rd_log.push_back(a);
            rd_cnt++;
            if (resp_en != 0) begin
               d = (rand_delay != 0) ? int'($urandom_range(1, 6)) : ack_delay;
               repeat (d) @(negedge CLK);
               bus.sdram_ack  = 1'b1;
               bus.sdram_dout = model_data(a);
               @(negedge CLK);
               bus.sdram_ack = 1'b0;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Full 4-phase transaction on one client; hold = cycles req stays high after rdy.
   task automatic client_txn(input int idx, input logic [AW-1:0] a, input int hold);
      int k;
      chk("rdy_idle", 32'(rdy_w[idx]), 32'd0);
      c_addr[idx] = a;
      c_req[idx]  = 1'b1;
      k = 0;
      while (k < 300 && rdy_w[idx] !== 1'b1) begin
         @(negedge CLK);
         k++;
      end
      chk("rdy_rise", 32'(rdy_w[idx]), 32'd1);
      chk("dout", 32'(dout_w[idx]), 32'(model_data(a)));
      repeat (hold) begin
         @(negedge CLK);
         chk("rdy_hold", 32'(rdy_w[idx]), 32'd1);
         chk("dout_hold", 32'(dout_w[idx]), 32'(model_data(a)));
      end
      c_req[idx] = 1'b0;
      @(negedge CLK);
      chk("rdy_clear", 32'(rdy_w[idx]), 32'd0);
   endtask

   initial begin
      int ord [3];
      int n;
      int base;
      int cnt0;
      logic seen;
      logic [AW-1:0] ra [3];
      logic [2:0] mask;

      RST   = 1'b1;
      c_req = '0;
      for (int i = 0; i < 3; i++) c_addr[i] = '0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);

      // Reset state
      chk("rst_rdy", 32'(rdy_w), 32'd0);
      for (int i = 0; i < 3; i++) chk("rst_dout", 32'(dout_w[i]), 32'd0);
      chk("rst_rd", 32'(bus.sdram_rd), 32'd0);
      chk("rst_addr", 32'(bus.sdram_addr), 32'd0);

      // All three request together at reset exit: OBJ, BG1, BG2
      base = rd_log.size();
      model_order(3'b111, ord, n);
      ra[0] = 25'h10; ra[1] = 25'h20; ra[2] = 25'h30;
      fork
         client_txn(0, ra[0], 0);
         client_txn(1, ra[1], 0);
         client_txn(2, ra[2], 0);
      join
      chk("simul_cnt", 32'(rd_log.size() - base), 32'(n));
      for (int j = 0; j < n; j++) chk("simul_order", 32'(rd_log[base+j]), 32'(ra[ord[j]]));
      chk("simul_rdy", 32'(rdy_w), 32'd0);

      // Single OBJ read, ack 5 cycles later, data held for a while
      base = rd_log.size();
      model_order(3'b001, ord, n);
      client_txn(0, 25'h000123, 4);
      chk("single_cnt", 32'(rd_log.size() - base), 32'd1);
      chk("single_addr", 32'(rd_log[base]), 32'h123);

      // BG1 keeps req high after rdy: no second read; new req served again
      cnt0 = rd_cnt;
      model_order(3'b010, ord, n);
      client_txn(1, 25'h200, 10);
      chk("hold_cnt", 32'(rd_cnt - cnt0), 32'd1);
      model_order(3'b010, ord, n);
      client_txn(1, 25'h204, 0);
      chk("rereq_cnt", 32'(rd_cnt - cnt0), 32'd2);

      // BG2 cancels after grant; OBJ queued behind it
      ack_delay = 6;
      base = rd_log.size();
      model_order(3'b101, ord, n);
      ra[2] = 25'h300; ra[0] = 25'h301;
      c_addr[2] = ra[2]; c_addr[0] = ra[0];
      c_req[2] = 1'b1; c_req[0] = 1'b1;
      @(negedge CLK);
      chk("lat_rd0", 32'(bus.sdram_rd), 32'd0);
      @(negedge CLK);
      chk("lat_rd1", 32'(bus.sdram_rd), 32'd1);
      chk("lat_addr", 32'(bus.sdram_addr), 32'(ra[ord[0]]));
      c_req[ord[0]] = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 300 && rdy_w[ord[1]] !== 1'b1; k++) begin
         @(negedge CLK);
         seen = seen | rdy_w[ord[0]];
      end
      chk("cancel_rdy", 32'(seen), 32'd0);
      chk("queued_rdy", 32'(rdy_w[ord[1]]), 32'd1);
      chk("queued_dout", 32'(dout_w[ord[1]]), 32'(model_data(ra[ord[1]])));
      chk("cancel_cnt", 32'(rd_log.size() - base), 32'd2);
      chk("cancel_addr1", 32'(rd_log[base+1]), 32'(ra[ord[1]]));
      c_req[ord[1]] = 1'b0;
      @(negedge CLK);
      chk("cancel_clr", 32'(rdy_w), 32'd0);
      ack_delay = 5;

      // Reset during WAIT, then a stray ack
      resp_en = 0;
      c_addr[0] = 25'h400;
      c_req[0]  = 1'b1;
      repeat (4) @(negedge CLK);
      RST = 1'b1;
      c_req[0] = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      ptr_m = 2;
      cnt0 = rd_cnt;
      stray_cnt++;
      repeat (4) @(negedge CLK);
      chk("rstw_rdy", 32'(rdy_w), 32'd0);
      chk("rstw_rd", 32'(bus.sdram_rd), 32'd0);
      chk("rstw_addr", 32'(bus.sdram_addr), 32'd0);
      chk("rstw_cnt", 32'(rd_cnt - cnt0), 32'd0);
      for (int i = 0; i < 3; i++) chk("rstw_dout", 32'(dout_w[i]), 32'd0);
      resp_en = 1;

      // Randomized rounds of simultaneous requests
      rand_delay = 1;
      for (int r = 0; r < 24; r++) begin
         mask = 3'($urandom_range(1, 7));
         for (int i = 0; i < 3; i++)
            ra[i] = 25'h10000 + 25'(r << 4) + 25'(i) + 25'($urandom_range(1, 255) << 16);
         base = rd_log.size();
         model_order(mask, ord, n);
         fork
            begin if (mask[0]) client_txn(0, ra[0], int'($urandom_range(0, 2))); end
            begin if (mask[1]) client_txn(1, ra[1], int'($urandom_range(0, 2))); end
            begin if (mask[2]) client_txn(2, ra[2], int'($urandom_range(0, 2))); end
         join
         chk("rnd_cnt", 32'(rd_log.size() - base), 32'(n));
         for (int j = 0; j < n; j++) chk("rnd_order", 32'(rd_log[base+j]), 32'(ra[ord[j]]));
      end
      rand_delay = 0;

      // Repeat of the same address by OBJ
      cnt0 = rd_cnt;
      model_order(3'b001, ord, n);
      client_txn(0, 25'h40, 0);
`ifdef XS_SDR_LASTWORD_CACHE_EN
      c_addr[0] = 25'h40;
      c_req[0]  = 1'b1;
      @(negedge CLK);
      chk("cache_rdy", 32'(rdy_w[0]), 32'd1);
      chk("cache_dout", 32'(dout_w[0]), 32'(model_data(25'h40)));
      c_req[0] = 1'b0;
      @(negedge CLK);
      chk("cache_clr", 32'(rdy_w[0]), 32'd0);
      chk("cache_cnt", 32'(rd_cnt - cnt0), 32'd1);
`else
      model_order(3'b001, ord, n);
      client_txn(0, 25'h40, 0);
      chk("nocache_cnt", 32'(rd_cnt - cnt0), 32'd2);
`endif
      model_order(3'b001, ord, n);
      client_txn(0, 25'h41, 0);
`ifdef XS_SDR_LASTWORD_CACHE_EN
      chk("miss_cnt", 32'(rd_cnt - cnt0), 32'd2);
`else
      chk("miss_cnt", 32'(rd_cnt - cnt0), 32'd3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/xs_sdr_rom_arbiter.md
Name: xs_sdr_rom_arbiter

Overview:
- SDRAM-side responder for the three graphics ROM fetch ports of the core: OBJ, BACK1 and BACK2.
- Each port is a 4-phase handshake: `req`/`addr` in, `rdy`/`dout` out.
- Accepts client requests, arbitrates round-robin, issues single 16-bit reads to the SDRAM controller read port, and returns the data to the requesting client.
- Sits between the core's `sdr_obj_*`, `sdr_bg1_*` and `sdr_bg2_*` buses and the platform SDRAM controller.

Parameters:
- AW, 25, client and SDRAM word address width.
- DW, 16, data width.

Ports:
- CLK  in  1  system clock (SDR_CLK domain; all logic on rising edge).
- RST  in  1  asynchronous, active-high reset.
- obj_addr  in  AW  OBJ client address, stable while obj_req high.
- obj_req  in  1  OBJ client request level.
- obj_rdy  out  1  OBJ data valid; held until obj_req low.
- obj_dout  out  DW  OBJ returned data.
- bg1_addr, bg1_req, bg1_rdy, bg1_dout: same as OBJ, for BACK1.
- bg2_addr, bg2_req, bg2_rdy, bg2_dout: same as OBJ, for BACK2.
- sdram_addr  out  AW  read address to the controller.
- sdram_rd  out  1  one-cycle read strobe.
- sdram_ack  in  1  one-cycle read-complete strobe.
- sdram_dout  in  DW  read data, valid in the sdram_ack cycle.

Behaviour:
- Reset values (asynchronous): all `*_rdy` = 0, all `*_dout` = 0, sdram_rd = 0, sdram_addr = 0.
  - FSM = IDLE; every client = FREE; round-robin pointer = BG2, so OBJ wins first.
- Per-client handshake state machine:
  - FREE→PEND when req = 1.
  - PEND→DONE when its data returns: rdy := 1 and dout := data, both held stable.
  - DONE→FREE when req = 0: rdy := 0 in the same edge.
  - A client with req still high in DONE is not re-served; the 4-phase rule prevents double service.
- Arbiter FSM:
  - IDLE: if any client is PEND, grant the first PEND client after the pointer in order OBJ→BG1→BG2→OBJ. Update the pointer, latch the granted index, drive sdram_addr from that client, and go to ISSUE.
  - ISSUE: sdram_rd = 1 for exactly one cycle, then WAIT. sdram_addr is held from ISSUE until ack.
  - WAIT: on sdram_ack, capture sdram_dout into the granted client's dout, move that client to DONE, and return to IDLE.
- Latency:
  - Client req sampled high at edge t (client FREE → PEND at t).
  - At edge t+1 the arbiter grants (IDLE→ISSUE), so sdram_rd = 1 during cycle t+1 to t+2.
  - Ack sampled at edge a ≥ t+3, so rdy = 1 after edge a.
  - Next grant possible at edge a+1, so the next sdram_rd follows one cycle later.
- sdram_ack outside WAIT is ignored; this covers stray acks after reset or cancel.
- Cancellation:
  - If req drops while PEND and not yet granted, the client returns to FREE and no read is issued.
  - If req drops after grant, the read completes on the SDRAM side, the data is discarded, rdy stays 0 and the client goes FREE.
- Simultaneous req from all three clients at reset exit: service order OBJ, BG1, BG2, then OBJ again.
- Asynchronous reset mid-WAIT aborts everything. The controller's pending ack is then discarded by the IDLE rule.

Optional Feature:
- Macro: XS_SDR_LASTWORD_CACHE_EN.
- Enabled: each client holds {valid, addr, data} of its last completed read.
  - On FREE→req with valid and addr equal to the cached addr, the client goes directly to DONE with rdy = 1 after the next edge and dout = cached data.
  - No arbitration and no sdram_rd.
  - Cache is updated on every completed read and cleared (valid = 0) on RST.
- Disabled: every request goes to SDRAM. Port list and timing are otherwise identical.

Test Plan:
- Single OBJ req, addr = 0x000123, ack 5 cycles after sdram_rd, sdram_dout = 0xBEEF → one sdram_rd with sdram_addr = 0x000123; obj_rdy = 1 and obj_dout = 0xBEEF held until obj_req = 0; obj_rdy clears at the next edge.
- OBJ, BG1 and BG2 request the same cycle, addrs 0x10/0x20/0x30 → sdram_rd sequence addrs 0x10, 0x20, 0x30; each rdy only on its own client.
- BG1 holds req high after rdy for 10 cycles → no second sdram_rd for BG1; a new req after a low phase is served again.
- BG2 drops req after grant before ack → sdram_rd issued once; bg2_rdy stays 0; the next queued client is granted after the ack.
- Reset asserted in WAIT, stray ack delivered after release → all rdy = 0, no client enters DONE, arbiter idle.
- With XS_SDR_LASTWORD_CACHE_EN: OBJ reads 0x40 twice → one sdram_rd; the second obj_rdy comes one edge after req with the same data. A read of 0x41 does go to SDRAM.
